// File: rtl/multicycle_ctrl_unit_pkg.sv
// Shared types and opcode constants for the multicycle RV32I control unit.
// FSM states, datapath mux selects, ALU operations and immediate formats live here.
package multicycle_ctrl_unit_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, HALT
  } state_t;

  typedef enum logic [1:0] {RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALURESULT = 2'd2} result_src_t;
  typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_REG = 2'd2, SRCA_ZERO = 2'd3} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_REG = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} alu_src_b_t;
  typedef enum logic {ADR_PC = 1'b0, ADR_RESULT = 1'b1} adr_src_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9
  } alu_op_t;

  // How the ALU decoder should interpret funct3/funct7_5 in the current state
  typedef enum logic [1:0] {AM_ADD = 2'd0, AM_SUB = 2'd1, AM_R = 2'd2, AM_I = 2'd3} alu_mode_t;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_src_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_unit_if.sv
// Memory request/ready handshake between the control unit and the memory system.
interface multicycle_ctrl_unit_if;
  logic mem_req;
  logic mem_ready;

  modport master (output mem_req, input mem_ready);
  modport slave  (input mem_req, output mem_ready);
endinterface

// File: rtl/ctrl_alu_decoder.sv
// Combinational ALU-operation and immediate-format decoder.
module ctrl_alu_decoder
  import multicycle_ctrl_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  alu_mode_t  alu_mode,
  output alu_op_t    alu_control,
  output imm_src_t   imm_src
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_mode)
      AM_SUB: alu_control = ALU_SUB;
      AM_R, AM_I: begin
        case (funct3)
          // Only R-type uses bit 30 to pick sub; addi's bit 30 is immediate data
          3'b000:  alu_control = (alu_mode == AM_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:         imm_src = IMM_S;
      OP_BRANCH:        imm_src = IMM_B;
      OP_JAL:           imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      default:          imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle RV32I control unit: main FSM, branch resolution and retired-instruction counter.
// All enables and mem_req are forced low while rstn is asserted.
module multicycle_ctrl_unit
  import multicycle_ctrl_unit_pkg::*;
#(
  parameter int BRANCH_EXT = 1,
  parameter int UPPER_EN   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  multicycle_ctrl_unit_if.master mem,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  input  logic                  neg,
  input  logic                  carry,
  input  logic                  ovf,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output result_src_t           ResultSrc,
  output alu_src_a_t            ALUSrcA,
  output alu_src_b_t            ALUSrcB,
  output adr_src_t              AdrSrc,
  output alu_op_t               ALUControl,
  output imm_src_t              immSrc,
  output logic                  illegal_instr,
  output logic [CNT_W-1:0]      instret
);

  state_t    state, next_state;
  alu_mode_t alu_mode;
  logic      mem_req_c, pc_write_c, reg_write_c, mem_write_c, ir_write_c;
  logic      branch_legal;

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n,
                                        input logic c, input logic v);
    case (f3)
      F3_BEQ:  return z;
      F3_BNE:  return !z;
      F3_BLT:  return n ^ v;
      F3_BGE:  return !(n ^ v);
      F3_BLTU: return !c;
      F3_BGEU: return c;
      default: return 1'b0;
    endcase
  endfunction

  assign branch_legal = (BRANCH_EXT != 0) ? (funct3 != 3'b010 && funct3 != 3'b011)
                                          : (funct3 == F3_BEQ);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    mem_req_c   = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    alu_mode    = AM_ADD;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REG;
    ResultSrc   = RES_ALUOUT;
    AdrSrc      = ADR_PC;
    case (state)
      FETCH: begin
        mem_req_c  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ir_write_c = mem.mem_ready;
        pc_write_c = mem.mem_ready;
        if (mem.mem_ready) next_state = DECODE;
      end
      DECODE: begin
        // JALR's target is rs1+imm, so precompute that instead of the PC-relative target
        ALUSrcA = (opcode == OP_JALR) ? SRCA_REG : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_IALU:           next_state = EXECI;
          OP_BRANCH:         next_state = branch_legal ? BRANCH : HALT;
          OP_JAL:            next_state = JAL;
          OP_JALR:           next_state = JALR;
          OP_LUI, OP_AUIPC:  next_state = (UPPER_EN != 0) ? UPPER : HALT;
          default:           next_state = HALT;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_c = 1'b1;
        AdrSrc    = ADR_RESULT;
        if (mem.mem_ready) next_state = MEMWB;
      end
      MEMWRITE: begin
        mem_req_c   = 1'b1;
        AdrSrc      = ADR_RESULT;
        mem_write_c = mem.mem_ready;
        if (mem.mem_ready) next_state = FETCH;
      end
      MEMWB: begin
        reg_write_c = 1'b1;
        ResultSrc   = RES_DATA;
        next_state  = FETCH;
      end
      EXECR: begin
        ALUSrcA    = SRCA_REG;
        alu_mode   = AM_R;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        alu_mode   = AM_I;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        next_state  = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_REG;
        alu_mode   = AM_SUB;
        pc_write_c = branch_taken(funct3, zero, neg, carry, ovf);
        next_state = FETCH;
      end
      JAL, JALR: begin
        // PC takes the target held in ALUOut while the ALU forms the link address
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write_c = 1'b1;
        next_state = ALUWB;
      end
      UPPER: begin
        ALUSrcA    = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        next_state = ALUWB;
      end
      HALT:    next_state = HALT;
      default: next_state = HALT;
    endcase
  end

  assign mem.mem_req   = mem_req_c & rstn;
  assign PCWrite       = pc_write_c & rstn;
  assign RegWrite      = reg_write_c & rstn;
  assign MemWrite      = mem_write_c & rstn;
  assign IRWrite       = ir_write_c & rstn;
  assign illegal_instr = (state == HALT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      instret <= '0;
    else if (next_state == FETCH && state != FETCH)
      instret <= instret + CNT_W'(1);
  end

  ctrl_alu_decoder u_alu_dec (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_mode    (alu_mode),
    .alu_control (ALUControl),
    .imm_src     (immSrc)
  );

endmodule
